// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/DM memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        OWN_IF = 2'd1,
        OWN_DM = 2'd2
    } arb_owner_e;

    localparam int MAX_STARVE_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_prio_sel.sv
// Winner selection between IF and DM with a saturating IF starvation counter.
// Latency: winner is combinational; counter updates on the grant edge.
// Backpressure: none here; grant strobes come from the accepted handshake.
module mem_arb_prio_sel
    import mem_arb_pkg::*;
#(
    parameter int MAX_STARVE = MAX_STARVE_DEFAULT
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       if_vld,
    input  logic       dm_vld,
    input  logic       if_grant,
    input  logic       dm_grant,
    output arb_owner_e winner
);

    localparam int CNT_W = $clog2(MAX_STARVE + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);

    logic [CNT_W-1:0] starve_cnt;

    // Count DM wins that kept a waiting IF out; an IF win clears the debt.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            starve_cnt <= '0;
        end else if (if_grant) begin
            starve_cnt <= '0;
        end else if (dm_grant && if_vld && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // DM has fixed priority unless IF has been starved for MAX_STARVE grants.
    always_comb begin
        winner = NONE;
        if (if_vld && dm_vld) begin
            winner = (starve_cnt == STARVE_MAX) ? OWN_IF : OWN_DM;
        end else if (dm_vld) begin
            winner = OWN_DM;
        end else if (if_vld) begin
            winner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF (read-only) and DM; single outstanding txn.
// Latency: request issues combinationally in IDLE; response routed same cycle as mem_rsp_valid_i.
// Backpressure: mem_req_ready_i low parks the grant in HOLD; ARB_PERF_CNT_EN adds grant/conflict counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = MAX_STARVE_DEFAULT
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                if_req_valid_i,
    input  logic [ADDR_W-1:0]   if_req_addr_i,
    output logic                if_req_ready_o,
    output logic                if_rsp_valid_o,
    output logic [DATA_W-1:0]   if_rsp_data_o,
    input  logic                dm_req_valid_i,
    input  logic                dm_req_we_i,
    input  logic [ADDR_W-1:0]   dm_req_addr_i,
    input  logic [DATA_W-1:0]   dm_req_wdata_i,
    input  logic [DATA_W/8-1:0] dm_req_be_i,
    output logic                dm_req_ready_o,
    output logic                dm_rsp_valid_o,
    output logic [DATA_W-1:0]   dm_rsp_data_o,
    output logic                mem_req_valid_o,
    output logic                mem_req_we_o,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic [DATA_W-1:0]   mem_req_wdata_o,
    output logic [DATA_W/8-1:0] mem_req_be_o,
    input  logic                mem_req_ready_i,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_W-1:0]   mem_rsp_data_i,
    output logic                busy_o
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         if_grant_cnt_o,
    output logic [31:0]         dm_grant_cnt_o,
    output logic [31:0]         conflict_cnt_o
`endif
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    arb_owner_e winner;
    arb_owner_e sel;
    logic       if_grant;
    logic       dm_grant;

    mem_arb_prio_sel #(
        .MAX_STARVE (MAX_STARVE)
    ) u_prio_sel (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .if_vld   (if_req_valid_i),
        .dm_vld   (dm_req_valid_i),
        .if_grant (if_grant),
        .dm_grant (dm_grant),
        .winner   (winner)
    );

    // Who drives the memory request: fresh winner in IDLE, latched owner in HOLD.
    always_comb begin
        sel = NONE;
        case (state_q)
            IDLE:    sel = winner;
            HOLD:    sel = owner_q;
            default: sel = NONE;
        endcase
    end

    assign if_grant = (sel == OWN_IF) && if_req_valid_i && mem_req_ready_i;
    assign dm_grant = (sel == OWN_DM) && dm_req_valid_i && mem_req_ready_i;

    // State and owner registers.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            owner_q <= NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Next state: grant sticks through HOLD; back to IDLE only on a response.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (winner != NONE) begin
                    owner_d = winner;
                    state_d = (if_grant || dm_grant) ? WAIT_RSP : HOLD;
                end
            end
            HOLD: begin
                if (if_grant || dm_grant) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid_i) begin
                    state_d = IDLE;
                    owner_d = NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = NONE;
            end
        endcase
    end

    // Outputs: request mux from the selected requester, response routed to the owner.
    always_comb begin
        if_req_ready_o  = 1'b0;
        dm_req_ready_o  = 1'b0;
        if_rsp_valid_o  = 1'b0;
        dm_rsp_valid_o  = 1'b0;
        if_rsp_data_o   = '0;
        dm_rsp_data_o   = '0;
        mem_req_valid_o = 1'b0;
        mem_req_we_o    = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_wdata_o = '0;
        mem_req_be_o    = '0;
        busy_o          = (state_q != IDLE);

        case (sel)
            OWN_IF: begin
                mem_req_valid_o = if_req_valid_i;
                mem_req_addr_o  = if_req_addr_i;
                mem_req_be_o    = '1;
                if_req_ready_o  = if_grant;
            end
            OWN_DM: begin
                mem_req_valid_o = dm_req_valid_i;
                mem_req_we_o    = dm_req_we_i;
                mem_req_addr_o  = dm_req_addr_i;
                mem_req_wdata_o = dm_req_wdata_i;
                mem_req_be_o    = dm_req_be_i;
                dm_req_ready_o  = dm_grant;
            end
            default: ;
        endcase

        // Responses outside WAIT_RSP are stray and never reach a requester.
        if (state_q == WAIT_RSP) begin
            if_rsp_data_o  = mem_rsp_data_i;
            dm_rsp_data_o  = mem_rsp_data_i;
            if_rsp_valid_o = mem_rsp_valid_i && (owner_q == OWN_IF);
            dm_rsp_valid_o = mem_rsp_valid_i && (owner_q == OWN_DM);
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic contended;
    assign contended = ((state_q == IDLE) || (state_q == HOLD)) && if_req_valid_i && dm_req_valid_i;

    // Saturating grant and contention counters.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if_grant_cnt_o <= '0;
            dm_grant_cnt_o <= '0;
            conflict_cnt_o <= '0;
        end else begin
            if (if_grant && (if_grant_cnt_o != 32'hFFFF_FFFF)) begin
                if_grant_cnt_o <= if_grant_cnt_o + 32'd1;
            end
            if (dm_grant && (dm_grant_cnt_o != 32'hFFFF_FFFF)) begin
                dm_grant_cnt_o <= dm_grant_cnt_o + 32'd1;
            end
            if (contended && (conflict_cnt_o != 32'hFFFF_FFFF)) begin
                conflict_cnt_o <= conflict_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default MAX_STARVE=4).
// Latency: inputs driven 1ns after the rising edge, outputs sampled mid-cycle.
// Backpressure: exercised through mem_req_ready_i held low.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        if_req_valid_i = 1'b0;
    logic [31:0] if_req_addr_i = '0;
    logic        if_req_ready_o;
    logic        if_rsp_valid_o;
    logic [31:0] if_rsp_data_o;
    logic        dm_req_valid_i = 1'b0;
    logic        dm_req_we_i = 1'b0;
    logic [31:0] dm_req_addr_i = '0;
    logic [31:0] dm_req_wdata_i = '0;
    logic [3:0]  dm_req_be_i = '0;
    logic        dm_req_ready_o;
    logic        dm_rsp_valid_o;
    logic [31:0] dm_rsp_data_o;
    logic        mem_req_valid_o;
    logic        mem_req_we_o;
    logic [31:0] mem_req_addr_o;
    logic [31:0] mem_req_wdata_o;
    logic [3:0]  mem_req_be_o;
    logic        mem_req_ready_i = 1'b0;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_data_i = '0;
    logic        busy_o;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_grant_cnt_o;
    logic [31:0] dm_grant_cnt_o;
    logic [31:0] conflict_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .if_req_valid_i  (if_req_valid_i),
        .if_req_addr_i   (if_req_addr_i),
        .if_req_ready_o  (if_req_ready_o),
        .if_rsp_valid_o  (if_rsp_valid_o),
        .if_rsp_data_o   (if_rsp_data_o),
        .dm_req_valid_i  (dm_req_valid_i),
        .dm_req_we_i     (dm_req_we_i),
        .dm_req_addr_i   (dm_req_addr_i),
        .dm_req_wdata_i  (dm_req_wdata_i),
        .dm_req_be_i     (dm_req_be_i),
        .dm_req_ready_o  (dm_req_ready_o),
        .dm_rsp_valid_o  (dm_rsp_valid_o),
        .dm_rsp_data_o   (dm_rsp_data_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_we_o    (mem_req_we_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_wdata_o (mem_req_wdata_o),
        .mem_req_be_o    (mem_req_be_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .busy_o          (busy_o)
`ifdef ARB_PERF_CNT_EN
        ,
        .if_grant_cnt_o  (if_grant_cnt_o),
        .dm_grant_cnt_o  (dm_grant_cnt_o),
        .conflict_cnt_o  (conflict_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        if_req_valid_i = 1'b0;
        dm_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i = '0;
        cyc();
        cyc();
        reset_i = 1'b1;
    endtask

    logic [5:0] dm_order;
    int         exp_cnt [6];

    initial begin
        dm_order = 6'b101111;
        exp_cnt  = '{0, 1, 2, 3, 4, 0};

        // ---- reset state ----
        cyc();
        cyc();
        #4;
        chk("rst_busy", busy_o, 0);
        chk("rst_if_rdy", if_req_ready_o, 0);
        chk("rst_dm_rdy", dm_req_ready_o, 0);
        chk("rst_mem_vld", mem_req_valid_o, 0);
        chk("rst_if_rsp", if_rsp_valid_o, 0);
        chk("rst_dm_rsp", dm_rsp_valid_o, 0);
        chk("rst_mem_addr", mem_req_addr_o, 0);
        chk("rst_mem_be", mem_req_be_o, 0);
        cyc();
        reset_i = 1'b1;

        // ---- IF alone reads 0x100, response two cycles later ----
        if_req_valid_i = 1'b1;
        if_req_addr_i = 32'h100;
        mem_req_ready_i = 1'b1;
        #4;
        chk("if_c0_rdy", if_req_ready_o, 1);
        chk("if_c0_mem_vld", mem_req_valid_o, 1);
        chk("if_c0_addr", mem_req_addr_o, 32'h100);
        chk("if_c0_we", mem_req_we_o, 0);
        chk("if_c0_be", mem_req_be_o, 4'hF);
        chk("if_c0_busy", busy_o, 0);
        cyc();
        if_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b0;
        #4;
        chk("if_c1_busy", busy_o, 1);
        chk("if_c1_mem_vld", mem_req_valid_o, 0);
        chk("if_c1_rsp", if_rsp_valid_o, 0);
        cyc();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i = 32'hDEADBEEF;
        #4;
        chk("if_c2_rsp", if_rsp_valid_o, 1);
        chk("if_c2_data", if_rsp_data_o, 32'hDEADBEEF);
        chk("if_c2_dm_rsp", dm_rsp_valid_o, 0);
        chk("if_c2_busy", busy_o, 1);
        cyc();
        mem_rsp_valid_i = 1'b0;
        #4;
        chk("if_c3_busy", busy_o, 0);
        cyc();

        // ---- both valid every cycle: DM,DM,DM,DM,IF,DM ----
        if_req_valid_i = 1'b1;
        if_req_addr_i = 32'h400;
        dm_req_valid_i = 1'b1;
        dm_req_we_i = 1'b0;
        dm_req_addr_i = 32'h800;
        dm_req_be_i = 4'hF;
        mem_req_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_rsp_valid_i = 1'b0;
            #4;
            chk($sformatf("order%0d_starve", i), dut.u_prio_sel.starve_cnt, exp_cnt[i]);
            chk($sformatf("order%0d_dm_rdy", i), dm_req_ready_o, dm_order[i]);
            chk($sformatf("order%0d_if_rdy", i), if_req_ready_o, !dm_order[i]);
            cyc();
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i = 32'(i);
            #4;
            chk($sformatf("order%0d_dm_rsp", i), dm_rsp_valid_o, dm_order[i]);
            chk($sformatf("order%0d_if_rsp", i), if_rsp_valid_o, !dm_order[i]);
            cyc();
        end
        mem_rsp_valid_i = 1'b0;
        if_req_valid_i = 1'b0;
        dm_req_valid_i = 1'b0;
        cyc();

        // ---- DM write held off by memory for 3 cycles ----
        dm_req_valid_i = 1'b1;
        dm_req_we_i = 1'b1;
        dm_req_addr_i = 32'h200;
        dm_req_wdata_i = 32'h12345678;
        dm_req_be_i = 4'h3;
        mem_req_ready_i = 1'b0;
        #4;
        chk("wr_c0_mem_vld", mem_req_valid_o, 1);
        chk("wr_c0_we", mem_req_we_o, 1);
        chk("wr_c0_dm_rdy", dm_req_ready_o, 0);
        cyc();
        if_req_valid_i = 1'b1;
        if_req_addr_i = 32'h300;
        #4;
        chk("wr_hold_busy", busy_o, 1);
        chk("wr_hold_addr", mem_req_addr_o, 32'h200);
        chk("wr_hold_if_rdy", if_req_ready_o, 0);
        cyc();
        #4;
        chk("wr_hold_wdata", mem_req_wdata_o, 32'h12345678);
        chk("wr_hold_be", mem_req_be_o, 4'h3);
        cyc();
        mem_req_ready_i = 1'b1;
        #4;
        chk("wr_acc_dm_rdy", dm_req_ready_o, 1);
        chk("wr_acc_if_rdy", if_req_ready_o, 0);
        chk("wr_acc_addr", mem_req_addr_o, 32'h200);
        cyc();
        dm_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        #4;
        chk("wr_ack_dm", dm_rsp_valid_o, 1);
        chk("wr_ack_if", if_rsp_valid_o, 0);
        chk("wr_ack_mem_vld", mem_req_valid_o, 0);
        cyc();
        mem_rsp_valid_i = 1'b0;

        // ---- IF parked in HOLD drops valid, DM arrives, IF returns ----
        #4;
        chk("hold_if_mem_vld", mem_req_valid_o, 1);
        chk("hold_if_addr", mem_req_addr_o, 32'h300);
        cyc();
        if_req_valid_i = 1'b0;
        dm_req_valid_i = 1'b1;
        dm_req_we_i = 1'b0;
        mem_req_ready_i = 1'b1;
        #4;
        chk("hold_drop_mem_vld", mem_req_valid_o, 0);
        chk("hold_drop_dm_rdy", dm_req_ready_o, 0);
        chk("hold_drop_busy", busy_o, 1);
        cyc();
        dm_req_valid_i = 1'b0;
        if_req_valid_i = 1'b1;
        #4;
        chk("hold_back_if_rdy", if_req_ready_o, 1);
        cyc();
        if_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i = 32'hCAFE0001;
        #4;
        chk("hold_back_rsp", if_rsp_valid_o, 1);
        chk("hold_back_data", if_rsp_data_o, 32'hCAFE0001);
        cyc();

        // ---- spurious response in IDLE ----
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i = 32'hBAD0BAD0;
        #4;
        chk("spur_if_rsp", if_rsp_valid_o, 0);
        chk("spur_dm_rsp", dm_rsp_valid_o, 0);
        cyc();
        mem_rsp_valid_i = 1'b0;
        #4;
        chk("spur_busy", busy_o, 0);
        cyc();

        // ---- reset during WAIT_RSP, late response dropped ----
        if_req_valid_i = 1'b1;
        if_req_addr_i = 32'h500;
        mem_req_ready_i = 1'b1;
        cyc();
        if_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b0;
        reset_i = 1'b0;
        #4;
        chk("rwait_busy_pre", busy_o, 1);
        cyc();
        reset_i = 1'b1;
        #4;
        chk("rwait_busy_rst", busy_o, 0);
        cyc();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i = 32'h55AA55AA;
        #4;
        chk("rwait_if_rsp", if_rsp_valid_o, 0);
        chk("rwait_dm_rsp", dm_rsp_valid_o, 0);
        chk("rwait_busy", busy_o, 0);
        chk("rwait_mem_vld", mem_req_valid_o, 0);
        cyc();
        mem_rsp_valid_i = 1'b0;
        if_req_valid_i = 1'b1;
        if_req_addr_i = 32'h600;
        mem_req_ready_i = 1'b1;
        #4;
        chk("rwait_next_rdy", if_req_ready_o, 1);
        chk("rwait_next_addr", mem_req_addr_o, 32'h600);
        cyc();
        if_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i = 32'h0000F00D;
        #4;
        chk("rwait_next_rsp", if_rsp_valid_o, 1);
        chk("rwait_next_data", if_rsp_data_o, 32'h0000F00D);
        cyc();
        mem_rsp_valid_i = 1'b0;

`ifdef ARB_PERF_CNT_EN
        // ---- performance counters over 10 contended transactions ----
        do_reset();
        if_req_valid_i = 1'b1;
        dm_req_valid_i = 1'b1;
        dm_req_we_i = 1'b0;
        mem_req_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_rsp_valid_i = 1'b0;
            cyc();
            mem_rsp_valid_i = 1'b1;
            cyc();
        end
        mem_rsp_valid_i = 1'b0;
        if_req_valid_i = 1'b0;
        dm_req_valid_i = 1'b0;
        #4;
        chk("perf_dm_cnt", dm_grant_cnt_o, 8);
        chk("perf_if_cnt", if_grant_cnt_o, 2);
        chk("perf_conflict", conflict_cnt_o, 10);
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
